// File: rtl/dpram_byte_reader_pkg.sv
// rtl/dpram_byte_reader_pkg.sv - shared sizes and helpers for the dual-port RAM byte reader
package dpram_reader_pkg;

    localparam int PTR_W      = 13;
    localparam int WADDR_W    = 11;
    localparam int FIFO_DEPTH = 3;

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [WADDR_W-1:0] waddr_t;
    typedef logic [1:0]         fifo_idx_t;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

    function automatic fifo_idx_t fifo_idx_next(input fifo_idx_t idx);
        return (idx == fifo_idx_t'(FIFO_DEPTH - 1)) ? '0 : idx + fifo_idx_t'(1);
    endfunction

endpackage

// File: rtl/dpram_byte_reader_if.sv
// rtl/dpram_byte_reader_if.sv - control, RAM port B and byte stream bundle
interface dpram_byte_reader_if;

    logic                               enable;
    logic                               flush;
    logic [dpram_reader_pkg::PTR_W-1:0] wrptr;
    logic [dpram_reader_pkg::PTR_W-1:0] rdptr;
    logic [dpram_reader_pkg::WADDR_W-1:0] ram_addr;
    logic [31:0]                        ram_rddata;
    logic [7:0]                         m_data;
    logic                               m_valid;
    logic                               m_ready;

    modport master (
        input  enable, flush, wrptr, ram_rddata, m_ready,
        output rdptr, ram_addr, m_data, m_valid
    );

    modport slave (
        output enable, flush, wrptr, ram_rddata, m_ready,
        input  rdptr, ram_addr, m_data, m_valid
    );

endinterface

// File: rtl/dpram_byte_reader_fifo.sv
// rtl/dpram_byte_reader_fifo.sv - 3-entry 8-bit synchronous FIFO with clear
module byte_fifo3
    import dpram_reader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic [7:0] o_head,
    output logic [1:0] o_count
);

    logic [7:0] r_mem [FIFO_DEPTH];
    fifo_idx_t  r_rd_idx;
    fifo_idx_t  r_wr_idx;
    logic [1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_idx] <= i_din;
                r_wr_idx        <= fifo_idx_next(r_wr_idx);
            end
            if (i_pop) begin
                r_rd_idx <= fifo_idx_next(r_rd_idx);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_idx];
    assign o_count = r_count;

endmodule

// File: rtl/dpram_byte_reader.sv
// rtl/dpram_byte_reader.sv - streams bytes from a RAM ring buffer via port B
module dpram_byte_reader
    import dpram_reader_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    dpram_byte_reader_if.master bus
);

    ptr_t       r_fptr;
    ptr_t       r_rdptr;
    logic       r_inflight;
    logic [1:0] r_sel;

    logic       w_issue;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count;
    logic [7:0] w_head;
    logic [2:0] w_occupancy;

    // Bytes already buffered plus the one on its way back must leave a free slot.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_issue     = bus.enable && !bus.flush && (r_fptr != bus.wrptr)
                         && (w_occupancy < 3'(FIFO_DEPTH));
    assign w_push      = r_inflight && !bus.flush;
    assign w_pop       = bus.m_valid && bus.m_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fptr     <= '0;
            r_rdptr    <= '0;
            r_inflight <= 1'b0;
            r_sel      <= '0;
        end else if (bus.flush) begin
            r_fptr     <= bus.wrptr;
            r_rdptr    <= bus.wrptr;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fptr <= r_fptr + ptr_t'(1);
                r_sel  <= r_fptr[1:0];
            end
            if (w_pop) begin
                r_rdptr <= r_rdptr + ptr_t'(1);
            end
        end
    end

    byte_fifo3 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (bus.flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (lane_byte(bus.ram_rddata, r_sel)),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.ram_addr = r_fptr[PTR_W-1 -: WADDR_W];
    assign bus.rdptr    = r_rdptr;
    assign bus.m_data   = w_head;
    assign bus.m_valid  = (w_count != 2'd0);

endmodule

// File: tb/tb_dpram_byte_reader.sv
// tb/tb_dpram_byte_reader.sv - directed self-checking bench for dpram_byte_reader
module tb_dpram_byte_reader;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:2047];

    dpram_byte_reader_if bus ();

    dpram_byte_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.ram_rddata <= mem[bus.ram_addr];

    function automatic logic [7:0] exp_byte(input int a);
        int v;
        if (a < 4) begin
            v = 'h11 * (a + 1);
        end else begin
            v = (a * 7 + 3) ^ (a >> 8);
        end
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_bytes(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("valid[%0d]", (start + i) % 8192), 32'(bus.m_valid), 32'd1);
            chk($sformatf("data[%0d]", (start + i) % 8192), 32'(bus.m_data),
                32'(exp_byte((start + i) % 8192)));
            tick();
        end
    endtask

    initial begin
        for (int w = 0; w < 2048; w++) begin
            for (int l = 0; l < 4; l++) begin
                mem[w][8*l +: 8] = exp_byte(4 * w + l);
            end
        end
        bus.ram_rddata = '0;
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.flush   = 1'b0;
        bus.wrptr   = '0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_valid", 32'(bus.m_valid), 32'd0);
        chk("reset_data", 32'(bus.m_data), 32'd0);
        chk("reset_rdptr", 32'(bus.rdptr), 32'd0);
        chk("reset_addr", 32'(bus.ram_addr), 32'd0);
        chk("word0", mem[0], 32'h44332211);

        // First word: two-cycle latency then four back-to-back bytes.
        bus.enable  = 1'b1;
        bus.m_ready = 1'b1;
        bus.wrptr   = 13'd4;
        tick();
        chk("lat_valid_t1", 32'(bus.m_valid), 32'd0);
        tick();
        chk("b0", 32'(bus.m_data), 32'h11);
        chk("b0_valid", 32'(bus.m_valid), 32'd1);
        tick();
        chk("b1", 32'(bus.m_data), 32'h22);
        tick();
        chk("b2", 32'(bus.m_data), 32'h33);
        tick();
        chk("b3", 32'(bus.m_data), 32'h44);
        chk("b3_valid", 32'(bus.m_valid), 32'd1);
        tick();
        chk("t1_idle_valid", 32'(bus.m_valid), 32'd0);
        chk("t1_rdptr", 32'(bus.rdptr), 32'd4);
        chk("t1_addr", 32'(bus.ram_addr), 32'd1);

        // Backpressure: FIFO fills to three, fetch pointer parks at 7.
        bus.m_ready = 1'b0;
        bus.wrptr   = 13'd14;
        repeat (6) tick();
        chk("bp_valid", 32'(bus.m_valid), 32'd1);
        chk("bp_data", 32'(bus.m_data), 32'(exp_byte(4)));
        chk("bp_addr", 32'(bus.ram_addr), 32'd1);
        chk("bp_rdptr", 32'(bus.rdptr), 32'd4);
        tick();
        tick();
        chk("bp_data_stable", 32'(bus.m_data), 32'(exp_byte(4)));
        chk("bp_addr_stable", 32'(bus.ram_addr), 32'd1);
        bus.m_ready = 1'b1;
        expect_bytes(4, 10);
        chk("bp_idle_valid", 32'(bus.m_valid), 32'd0);
        chk("bp_rdptr_end", 32'(bus.rdptr), 32'd14);

        // Wrap across 8191 -> 0.
        bus.flush = 1'b1;
        bus.wrptr = 13'd8190;
        tick();
        bus.flush = 1'b0;
        chk("wr_flush_valid", 32'(bus.m_valid), 32'd0);
        chk("wr_flush_rdptr", 32'(bus.rdptr), 32'd8190);
        chk("wr_flush_addr", 32'(bus.ram_addr), 32'd2047);
        bus.wrptr = 13'd2;
        tick();
        tick();
        expect_bytes(8190, 4);
        chk("wr_rdptr", 32'(bus.rdptr), 32'd2);
        chk("wr_idle_valid", 32'(bus.m_valid), 32'd0);

        // Flush with two bytes buffered and one fetch in flight.
        bus.m_ready = 1'b0;
        bus.wrptr   = 13'd10;
        tick();
        tick();
        tick();
        chk("fl_pre_valid", 32'(bus.m_valid), 32'd1);
        chk("fl_pre_data", 32'(bus.m_data), 32'(exp_byte(2)));
        chk("fl_pre_addr", 32'(bus.ram_addr), 32'd1);
        bus.flush = 1'b1;
        bus.wrptr = 13'd100;
        tick();
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        chk("fl_valid", 32'(bus.m_valid), 32'd0);
        chk("fl_rdptr", 32'(bus.rdptr), 32'd100);
        chk("fl_addr", 32'(bus.ram_addr), 32'd25);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_no_stale[%0d]", i), 32'(bus.m_valid), 32'd0);
        end
        bus.wrptr = 13'd103;
        tick();
        tick();
        expect_bytes(100, 3);
        chk("fl_post_valid", 32'(bus.m_valid), 32'd0);
        chk("fl_post_rdptr", 32'(bus.rdptr), 32'd103);

        // Enable dropped mid-stream, then restored.
        bus.wrptr = 13'd123;
        tick();
        tick();
        chk("en_b103", 32'(bus.m_data), 32'(exp_byte(103)));
        tick();
        chk("en_b104", 32'(bus.m_data), 32'(exp_byte(104)));
        bus.enable = 1'b0;
        tick();
        chk("en_drain_valid", 32'(bus.m_valid), 32'd1);
        chk("en_drain_b105", 32'(bus.m_data), 32'(exp_byte(105)));
        chk("en_addr_a", 32'(bus.ram_addr), 32'd26);
        tick();
        chk("en_empty_valid", 32'(bus.m_valid), 32'd0);
        chk("en_addr_b", 32'(bus.ram_addr), 32'd26);
        tick();
        tick();
        chk("en_still_empty", 32'(bus.m_valid), 32'd0);
        chk("en_addr_c", 32'(bus.ram_addr), 32'd26);
        chk("en_rdptr", 32'(bus.rdptr), 32'd106);
        bus.enable = 1'b1;
        tick();
        tick();
        expect_bytes(106, 17);
        chk("en_end_valid", 32'(bus.m_valid), 32'd0);
        chk("en_end_rdptr", 32'(bus.rdptr), 32'd123);

        // Reset while a byte is being presented.
        bus.wrptr = 13'd130;
        tick();
        tick();
        tick();
        chk("rs_pre_valid", 32'(bus.m_valid), 32'd1);
        reset     = 1'b1;
        bus.wrptr = 13'd0;
        tick();
        chk("rs_valid", 32'(bus.m_valid), 32'd0);
        chk("rs_rdptr", 32'(bus.rdptr), 32'd0);
        chk("rs_addr", 32'(bus.ram_addr), 32'd0);
        chk("rs_data", 32'(bus.m_data), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("rs_post_valid", 32'(bus.m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
